// File: rtl/valu_pipe.sv
// Lane-parallel execute pipeline: X stage (with iterative restoring divider) feeding a
// registered X2 output stage, both under valid/ready flow control.
module valu_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_pc,
  input  logic [15:0]            in_ins,
  input  logic [LANES*WIDTH-1:0] in_op1,
  input  logic [LANES*WIDTH-1:0] in_op2,
  input  logic [LANES*WIDTH-1:0] mem_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [15:0]            out_ins,
  output logic [WIDTH-1:0]       out_pc,
  output logic [LANES-1:0]       out_div_zero
);

  localparam int unsigned DW = LANES * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_ST0  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_LOAD = 4'b0111;
  localparam logic [3:0] OP_ST1  = 4'b1100;
  localparam logic [3:0] OP_ST2  = 4'b1101;
  localparam logic [3:0] OP_DOT  = 4'b1110;

  logic                        x_valid_q;
  logic [15:0]                 x_ins_q;
  logic [WIDTH-1:0]            x_pc_q;
  logic [DW-1:0]               x_op1_q;   // doubles as the quotient shift register while dividing
  logic [DW-1:0]               x_op2_q;
  logic [LANES-1:0][WIDTH-1:0] rem_q;
  logic [CW-1:0]               count_q;

  logic                        out_valid_q;
  logic [DW-1:0]               out_result_q;
  logic [15:0]                 out_ins_q;
  logic [WIDTH-1:0]            out_pc_q;
  logic [LANES-1:0]            out_div_zero_q;

  logic [LANES-1:0][WIDTH-1:0] op1_l, op2_l, quo_d, rem_d;
  logic [DW-1:0]               res_c;
  logic [LANES-1:0]            dz_c;
  logic [WIDTH-1:0]            dot_acc;
  logic [WIDTH-1:0]            prod;
  logic [WIDTH:0]              shifted, trial;
  logic                        taken;
  logic                        is_div, div_busy, x_done, x_adv;

  assign is_div   = (x_ins_q[15:12] == OP_DIV);
  assign div_busy = x_valid_q && is_div && (count_q != CW'(WIDTH));
  assign x_done   = x_valid_q && !(is_div && (count_q != CW'(WIDTH)));
  assign x_adv    = x_done && (!out_valid_q || out_ready);
  assign in_ready = !x_valid_q || x_adv;

  // Lane views plus one restoring-division step per lane
  always_comb begin
    shifted = '0;
    trial   = '0;
    for (int i = 0; i < LANES; i++) begin
      op1_l[i] = x_op1_q[i*WIDTH +: WIDTH];
      op2_l[i] = x_op2_q[i*WIDTH +: WIDTH];
      shifted  = {rem_q[i], op1_l[i][WIDTH-1]};
      trial    = shifted - {1'b0, op2_l[i]};
      if (!trial[WIDTH]) begin
        rem_d[i] = trial[WIDTH-1:0];
        quo_d[i] = {op1_l[i][WIDTH-2:0], 1'b1};
      end else begin
        rem_d[i] = shifted[WIDTH-1:0];
        quo_d[i] = {op1_l[i][WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result selection for the instruction currently in X
  always_comb begin
    res_c   = '0;
    dz_c    = '0;
    dot_acc = '0;
    prod    = '0;
    taken   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      prod    = op1_l[i] * op2_l[i];
      dot_acc = dot_acc + prod;
    end
    case (x_ins_q[15:12])
      OP_ADD: for (int i = 0; i < LANES; i++) res_c[i*WIDTH +: WIDTH] = op1_l[i] + op2_l[i];
      OP_SUB: for (int i = 0; i < LANES; i++) res_c[i*WIDTH +: WIDTH] = op1_l[i] - op2_l[i];
      OP_MUL: for (int i = 0; i < LANES; i++) res_c[i*WIDTH +: WIDTH] = op1_l[i] * op2_l[i];
      OP_DIV: begin
        // The raw quotient is meaningless for a zero divisor, so force all ones
        for (int i = 0; i < LANES; i++) begin
          dz_c[i] = (op2_l[i] == '0);
          res_c[i*WIDTH +: WIDTH] = dz_c[i] ? '1 : op1_l[i];
        end
      end
      OP_DOT: res_c[WIDTH-1:0] = dot_acc;
      OP_JMP: begin
        case (x_ins_q[7:4])
          4'd0:    taken = (op1_l[0] == '0);
          4'd1:    taken = (op1_l[0] != '0);
          4'd2:    taken = op1_l[0][WIDTH-1];
          4'd3:    taken = !op1_l[0][WIDTH-1];
          default: taken = 1'b0;
        endcase
        if (x_ins_q[7:6] == 2'b00)
          res_c[WIDTH-1:0] = taken ? op2_l[0] : x_pc_q + WIDTH'(2);
      end
      OP_LOAD: res_c = mem_data;
      OP_ST0, OP_ST1, OP_ST2: if (x_ins_q[7:4] == 4'd1) res_c = x_op1_q;
      default: res_c = '0;
    endcase
  end

  // X stage: capture, divide iterations, and release to X2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_valid_q <= 1'b0;
      x_ins_q   <= '0;
      x_pc_q    <= '0;
      x_op1_q   <= '0;
      x_op2_q   <= '0;
      rem_q     <= '0;
      count_q   <= '0;
    end else if (in_valid && in_ready) begin
      x_valid_q <= 1'b1;
      x_ins_q   <= in_ins;
      x_pc_q    <= in_pc;
      x_op1_q   <= in_op1;
      x_op2_q   <= in_op2;
      rem_q     <= '0;
      count_q   <= '0;
    end else if (x_adv) begin
      x_valid_q <= 1'b0;
    end else if (div_busy) begin
      x_op1_q   <= quo_d;
      rem_q     <= rem_d;
      count_q   <= count_q + CW'(1);
    end
  end

  // X2 stage: registered outputs, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_ins_q      <= '0;
      out_pc_q       <= '0;
      out_div_zero_q <= '0;
    end else if (x_adv) begin
      out_valid_q    <= 1'b1;
      out_result_q   <= res_c;
      out_ins_q      <= x_ins_q;
      out_pc_q       <= x_pc_q;
      out_div_zero_q <= dz_c;
    end else if (out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_ins      = out_ins_q;
  assign out_pc       = out_pc_q;
  assign out_div_zero = out_div_zero_q;

endmodule

// File: doc/valu_pipe.md
Name: valu_pipe

Overview:
- Parametrised, lane-parallel successor to the two-stage execute pipeline.
- Executes one 16-bit instruction over LANES operand lanes of WIDTH bits each.
- Adds valid/ready backpressure, an iterative multi-cycle divider with divide-by-zero flagging, and a lane-reducing dot-product mode.
- Sits between operand fetch/read (upstream) and writeback (downstream).

Parameters:
- WIDTH, 16, bits per lane and PC width (≥4).
- LANES, 4, number of operand lanes (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  X stage can accept.
- in_pc  in  WIDTH  instruction PC.
- in_ins  in  16  instruction; opcode [15:12], subcode [7:4].
- in_op1  in  LANES*WIDTH  operand 1; lane i at [i*WIDTH +: WIDTH].
- in_op2  in  LANES*WIDTH  operand 2.
- mem_data  in  LANES*WIDTH  load data; valid while the load occupies X.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  LANES*WIDTH  result lanes.
- out_ins  out  16  instruction carried with the result.
- out_pc  out  WIDTH  PC carried with the result.
- out_div_zero  out  LANES  per-lane divide-by-zero flag.

Behaviour:
- Reset (async, rst_n=0): x_valid=0, x2_valid=0, divider count=0; out_valid=0, out_result=0, out_ins=0, out_pc=0, out_div_zero=0; in_ready=1 on the first edge after release.
- Reset mid-division aborts the division; nothing is emitted.
- Handshakes:
  - in_ready = !x_valid || x_adv.
  - x_adv = x_done && (!x2_valid || out_ready).
  - X2 is replaced or cleared on edges where out_ready is high.
  - Input transfers on in_valid && in_ready; output transfers on out_valid && out_ready.
  - Outputs hold stable while out_valid && !out_ready.
- Timing:
  - Non-div: x_done=1 in the capture cycle. Accepted at edge N, out_valid from edge N+1.
  - Throughput is 1/cycle with out_ready held high; X and X2 move on the same edge.
  - Div (opcode 0011): restoring divider, one quotient bit per cycle, all lanes in parallel. x_done rises after WIDTH cycles in X; out_valid from edge N+WIDTH+1.
  - in_ready=0 while dividing.
- Per-lane arithmetic, mod 2^WIDTH, unsigned unless stated:
  - 0000 add: op1+op2.
  - 0001 sub: op1-op2.
  - 0010 mul: low WIDTH bits of op1*op2.
  - 0011 div: op1/op2. If op2==0, quotient is all ones and out_div_zero[i]=1; otherwise the flag is 0.
- 1110 dot: lane 0 = sum over lanes of low WIDTH bits of op1*op2, mod 2^WIDTH; other lanes 0.
- 0110 jump, lane 0 only, other lanes 0; target = op2 lane 0, else pc+2 mod 2^WIDTH:
  - sub 0 (jz): target if op1==0.
  - sub 1 (jnz): target if op1!=0.
  - sub 2 (js): target if op1[WIDTH-1]=1.
  - sub 3 (jns): target if op1[WIDTH-1]=0.
  - sub ≥4: result 0.
- Store (opcode 0100/1100/1101, subcode 1): result = op1 (all lanes).
- Load (0111): result = mem_data sampled on the X→X2 transfer edge; later mem_data changes are ignored.
- Any other opcode: result 0.
- out_div_zero is 0 for all non-div instructions.
- out_ins/out_pc always match the instruction in X2.

Test Plan:
- Reset and add: WIDTH=16, LANES=4. Assert rst_n=0 mid-stream → all outputs 0 immediately. Then add op1 lanes {1,2,3,0xFFFF}, op2 {1,1,1,1}, out_ready=1 → one cycle after acceptance, result {2,3,4,0x0000}, out_valid=1.
- Stream and backpressure: send 5 back-to-back subs, hold out_ready=0 for 3 cycles after the first result → in_ready drops after 2 accepted; first result held stable; all 5 results in order, none lost or duplicated.
- Divide: op1 {100,7,0xFFFF,5}, op2 {7,0,1,5} → result emerges 17 edges after acceptance as {14,0xFFFF,0xFFFF,1}, out_div_zero=0010b. in_ready=0 for 16 cycles. Separately, pulse rst_n low mid-division → no output.
- Dot: op1 {2,3,4,5}, op2 {10,10,10,10} → lane0=140, other lanes 0. With op1 lanes 0x8000 and op2 2 → lane0=0.
- Jumps: pc=0x0010, op2 lane0=0x0040. jz with op1=0 → 0x0040. jnz with op1=0 → 0x0012. js with op1=0x8000 → 0x0040. pc=0xFFFE and jz not taken → 0x0000.
- Load: change mem_data one cycle after the X→X2 transfer → out_result keeps the sampled value. Store with op1 lanes {9,8,7,6} → result {9,8,7,6}.
